// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the I/D memory port arbiter
// Contents: arb_state_t (IDLE, SERVE_I, SERVE_D) and arb_grant_t (GRANT_I, GRANT_D).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    localparam logic [1:0] BE_ALL = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundle of fetch, data and physical memory port signals
// Ports: fetch (i_*), data (d_*) and physical memory (pmem_*) groups.
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_request;
    logic [ADDR_W-1:0] i_address;
    logic              i_response;
    logic [DATA_W-1:0] i_rdata;

    logic              d_request;
    logic              d_write_enable;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_byte_enable;
    logic              d_response;
    logic [DATA_W-1:0] d_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [1:0]        pmem_byte_enable;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_request, i_address,
        output i_response, i_rdata,
        input  d_request, d_write_enable, d_address, d_wdata, d_byte_enable,
        output d_response, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_request, i_address,
        input  i_response, i_rdata,
        output d_request, d_write_enable, d_address, d_wdata, d_byte_enable,
        input  d_response, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data requests
// Ports: i_request_i, d_request_i, prefer_d_i (only with MEM_ARB_RR_EN),
//        valid_o (some request pending), grant_o (winning port).
// Macro MEM_ARB_RR_EN: simultaneous requests alternate using prefer_d_i;
// otherwise D always wins a tie.
import mem_arbiter_pkg::*;

module mem_arb_pick (
    input  logic       i_request_i,
    input  logic       d_request_i,
`ifdef MEM_ARB_RR_EN
    input  logic       prefer_d_i,
`endif
    output logic       valid_o,
    output arb_grant_t grant_o
);

    always_comb begin
        valid_o = i_request_i | d_request_i;
        grant_o = GRANT_I;
`ifdef MEM_ARB_RR_EN
        if (d_request_i && i_request_i)
            grant_o = prefer_d_i ? GRANT_D : GRANT_I;
        else if (d_request_i)
            grant_o = GRANT_D;
`else
        // D wins ties so a stalled MEM stage can never be starved by fetch.
        if (d_request_i)
            grant_o = GRANT_D;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one physical memory port between fetch (I) and data (D)
// Ports: clk, reset_n (async active-low), bus (mem_arbiter_if.slave).
// Winner's address/wdata/byte enables are latched in IDLE and held until pmem_resp;
// the response pulse and read data are combinational on pmem_resp.
// Macro MEM_ARB_RR_EN: round-robin tie breaking with a 1-bit pointer.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;
    logic              we_q;
    logic              read_q;
    logic              write_q;
    logic              pick_valid;
    arb_grant_t        pick_grant;

`ifdef MEM_ARB_RR_EN
    logic prefer_d_q;
`endif

    mem_arb_pick u_pick (
        .i_request_i (bus.i_request),
        .d_request_i (bus.d_request),
`ifdef MEM_ARB_RR_EN
        .prefer_d_i  (prefer_d_q),
`endif
        .valid_o     (pick_valid),
        .grant_o     (pick_grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prefer_d_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        if (pick_grant == GRANT_D) begin
                            state_q <= SERVE_D;
                            addr_q  <= bus.d_address;
                            wdata_q <= bus.d_wdata;
                            be_q    <= bus.d_byte_enable;
                            we_q    <= bus.d_write_enable;
                            read_q  <= ~bus.d_write_enable;
                            write_q <= bus.d_write_enable;
                        end else begin
                            state_q <= SERVE_I;
                            addr_q  <= bus.i_address;
                            wdata_q <= '0;
                            be_q    <= BE_ALL;
                            we_q    <= 1'b0;
                            read_q  <= 1'b1;
                            write_q <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Live requests are ignored here; only pmem_resp ends the cycle.
                    if (bus.pmem_resp) begin
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        prefer_d_q <= (state_q == SERVE_I);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_read        = read_q;
    assign bus.pmem_write       = write_q;
    assign bus.pmem_address     = addr_q;
    assign bus.pmem_wdata       = wdata_q;
    // Only a D store narrows the mask; reads and idle present a full word.
    assign bus.pmem_byte_enable = ((state_q == SERVE_D) && we_q) ? be_q : BE_ALL;

    assign bus.i_response = (state_q == SERVE_I) && bus.pmem_resp;
    assign bus.d_response = (state_q == SERVE_D) && bus.pmem_resp;
    assign bus.i_rdata    = bus.i_response ? bus.pmem_rdata : '0;
    assign bus.d_rdata    = bus.d_response ? bus.pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after the grant edge; pmem_resp rises after lat further cycles.
    task automatic serve(input logic is_d, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be,
                         input int lat, input logic [15:0] rdata);
        check_eq("serve_rd", {31'd0, bus.pmem_read}, {31'd0, ~we});
        check_eq("serve_wr", {31'd0, bus.pmem_write}, {31'd0, we});
        check_eq("serve_addr", {16'd0, bus.pmem_address}, {16'd0, addr});
        check_eq("serve_be", {30'd0, bus.pmem_byte_enable}, {30'd0, (we ? be : 2'b11)});
        if (we) check_eq("serve_wdata", {16'd0, bus.pmem_wdata}, {16'd0, wdata});
        for (int k = 0; k < lat; k++) begin
            step();
            check_eq("wait_addr", {16'd0, bus.pmem_address}, {16'd0, addr});
            check_eq("wait_strobe", {30'd0, bus.pmem_read, bus.pmem_write}, {30'd0, ~we, we});
            check_eq("wait_noresp", {30'd0, bus.i_response, bus.d_response}, 32'd0);
        end
        bus.pmem_rdata = rdata;
        bus.pmem_resp  = 1'b1;
        #1;
        check_eq("resp_i", {31'd0, bus.i_response}, {31'd0, ~is_d});
        check_eq("resp_d", {31'd0, bus.d_response}, {31'd0, is_d});
        if (is_d) check_eq("resp_d_rdata", {16'd0, bus.d_rdata}, {16'd0, rdata});
        else      check_eq("resp_i_rdata", {16'd0, bus.i_rdata}, {16'd0, rdata});
        step();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 16'h0;
        #1;
        check_eq("idle_strobe", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check_eq("idle_noresp", {30'd0, bus.i_response, bus.d_response}, 32'd0);
    endtask

    logic exp_d;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.i_request      = 1'b0;
        bus.i_address      = 16'h0;
        bus.d_request      = 1'b0;
        bus.d_write_enable = 1'b0;
        bus.d_address      = 16'h0;
        bus.d_wdata        = 16'h0;
        bus.d_byte_enable  = 2'b00;
        bus.pmem_rdata     = 16'h0;
        bus.pmem_resp      = 1'b0;
        step();
        step();
        check_eq("rst_strobe", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check_eq("rst_resp", {30'd0, bus.i_response, bus.d_response}, 32'd0);
        check_eq("rst_addr", {16'd0, bus.pmem_address}, 32'd0);
        check_eq("rst_wdata", {16'd0, bus.pmem_wdata}, 32'd0);
        check_eq("rst_be", {30'd0, bus.pmem_byte_enable}, 32'd3);
        reset_n = 1'b1;
        step();

        // Fetch read, pmem_resp three cycles after the strobe appears.
        bus.i_request = 1'b1;
        bus.i_address = 16'h3000;
        step();
        bus.i_request = 1'b0;
        serve(1'b0, 1'b0, 16'h3000, 16'h0, 2'b11, 3, 16'h1234);

        // Simultaneous requests: D store wins, then I is served after an IDLE cycle.
        bus.i_request      = 1'b1;
        bus.i_address      = 16'h3002;
        bus.d_request      = 1'b1;
        bus.d_write_enable = 1'b1;
        bus.d_address      = 16'h4001;
        bus.d_wdata        = 16'h00AB;
        bus.d_byte_enable  = 2'b10;
        step();
        bus.d_request = 1'b0;
        serve(1'b1, 1'b1, 16'h4001, 16'h00AB, 2'b10, 1, 16'h0);
        step();
        bus.i_request = 1'b0;
        serve(1'b0, 1'b0, 16'h3002, 16'h0, 2'b11, 0, 16'h5A5A);

        // Both held high for four accesses.
        bus.i_request      = 1'b1;
        bus.i_address      = 16'h3200;
        bus.d_request      = 1'b1;
        bus.d_write_enable = 1'b0;
        bus.d_address      = 16'h4100;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef MEM_ARB_RR_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            serve(exp_d, 1'b0, (exp_d ? 16'h4100 : 16'h3200), 16'h0, 2'b11, k % 2,
                  16'h1000 + 16'(k));
        end
        bus.i_request = 1'b0;
        bus.d_request = 1'b0;
        step();

        // D read: request dropped and address changed mid-access.
        bus.d_request      = 1'b1;
        bus.d_write_enable = 1'b0;
        bus.d_address      = 16'h5000;
        step();
        bus.d_request = 1'b0;
        bus.d_address = 16'h6000;
        serve(1'b1, 1'b0, 16'h5000, 16'h0, 2'b11, 2, 16'hC0DE);

        // Reset asserted during a D store.
        bus.d_request      = 1'b1;
        bus.d_write_enable = 1'b1;
        bus.d_address      = 16'h7000;
        bus.d_wdata        = 16'hBEEF;
        bus.d_byte_enable  = 2'b01;
        step();
        bus.d_request = 1'b0;
        check_eq("pre_rst_wr", {31'd0, bus.pmem_write}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_strobe", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check_eq("async_rst_addr", {16'd0, bus.pmem_address}, 32'd0);
        check_eq("async_rst_be", {30'd0, bus.pmem_byte_enable}, 32'd3);
        step();
        reset_n = 1'b1;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'hDEAD;
        #1;
        check_eq("late_resp_none", {30'd0, bus.i_response, bus.d_response}, 32'd0);
        step();
        bus.pmem_resp = 1'b0;
        bus.i_request = 1'b1;
        bus.i_address = 16'h3100;
        step();
        bus.i_request = 1'b0;
        serve(1'b0, 1'b0, 16'h3100, 16'h0, 2'b11, 1, 16'h7777);

        // pmem_resp while idle.
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h4444;
        #1;
        check_eq("idle_resp_none", {30'd0, bus.i_response, bus.d_response}, 32'd0);
        step();
        bus.pmem_resp = 1'b0;
        #1;
        check_eq("idle_stays", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
